// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: FSM state encoding, default MISR constants and the
// pattern counter width used by both the pattern generator and the analyzer.
package lbist_pkg;

  localparam int unsigned LBIST_W = 8;
  localparam int unsigned CNT_W   = 16;

  localparam logic [LBIST_W-1:0] LBIST_POLY = 8'hB8;
  localparam logic [LBIST_W-1:0] LBIST_SEED = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } ora_state_e;

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: shift left with tap-mask parity feedback,
// XOR in the response word. Load has priority over the update.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int unsigned       WIDTH   = LBIST_W,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(LBIST_POLY),
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(LBIST_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             fb_c;

  assign fb_c = ^(q_q & POLY);

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (en) begin
      q_d = {q_q[WIDTH-2:0], fb_c} ^ din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lbist_ora.sv
// LBIST output response analyzer: compacts NUM_PATTERNS accepted CUT responses
// into a MISR, then compares the final signature against GOLDEN.
module lbist_ora
  import lbist_pkg::*;
#(
  parameter int unsigned       WIDTH        = LBIST_W,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(LBIST_POLY),
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(LBIST_SEED),
  parameter int unsigned       NUM_PATTERNS = 255,
  parameter logic [WIDTH-1:0] GOLDEN       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  ora_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             misr_load_c;
  logic             misr_en_c;
  logic [WIDTH-1:0] misr_q;

  lbist_misr #(
    .WIDTH   (WIDTH),
    .POLY    (POLY),
    .RST_VAL (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load_c),
    .seed (SEED),
    .en   (misr_en_c),
    .din  (resp),
    .q    (misr_q)
  );

  // done is set from the DONE state itself, so it rises one edge after CHECK.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    misr_load_c = 1'b0;
    misr_en_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          misr_load_c = 1'b1;
          cnt_d       = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        done_d = 1'b0;
        if (resp_valid) begin
          misr_en_c = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        done_d  = 1'b0;
        pass_d  = (misr_q == GOLDEN);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          misr_load_c = 1'b1;
          cnt_d       = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          state_d     = ST_RUN;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;
  assign pat_count = cnt_q;

endmodule

// File: tb/tb_lbist_ora.sv
// Directed bench for lbist_ora: four instances share the stimulus and differ in
// pattern count, golden value and seed.
module tb_lbist_ora;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_valid;
  logic [7:0] resp;

  logic        busy_one, done_one, pass_one;
  logic [7:0]  sig_one;
  logic [15:0] cnt_one;
  logic        busy_two, done_two, pass_two;
  logic [7:0]  sig_two;
  logic [15:0] cnt_two;
  logic        busy_bad, done_bad, pass_bad;
  logic [7:0]  sig_bad;
  logic [15:0] cnt_bad;
  logic        busy_full, done_full, pass_full;
  logic [7:0]  sig_full;
  logic [15:0] cnt_full;

  int vectors = 0;
  int errors  = 0;

  localparam logic [7:0] FULL_SEED   = 8'hA5;
  localparam logic [7:0] FULL_GOLDEN = 8'hC3;

  always #5 clk = ~clk;

  lbist_ora #(.NUM_PATTERNS(1), .GOLDEN(8'h5A)) u_one (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .busy(busy_one), .done(done_one), .pass(pass_one),
    .signature(sig_one), .pat_count(cnt_one));

  lbist_ora #(.NUM_PATTERNS(2), .GOLDEN(8'h88)) u_two (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .busy(busy_two), .done(done_two), .pass(pass_two),
    .signature(sig_two), .pat_count(cnt_two));

  lbist_ora #(.NUM_PATTERNS(2), .GOLDEN(8'h89)) u_bad (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .busy(busy_bad), .done(done_bad), .pass(pass_bad),
    .signature(sig_bad), .pat_count(cnt_bad));

  lbist_ora #(.SEED(FULL_SEED), .NUM_PATTERNS(255), .GOLDEN(FULL_GOLDEN)) u_full (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .busy(busy_full), .done(done_full), .pass(pass_full),
    .signature(sig_full), .pat_count(cnt_full));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference MISR step with POLY=B8 taps written out explicitly.
  function automatic logic [7:0] mstep(input logic [7:0] m, input logic [7:0] d);
    logic fb;
    fb = m[7] ^ m[5] ^ m[4] ^ m[3];
    return {m[6:0], fb} ^ d;
  endfunction

  function automatic logic [7:0] pat(input int i);
    if (i == 0) return 8'h5A;
    if (i == 1) return 8'h3C;
    return 8'(i * 37 + 11);
  endfunction

  initial begin
    logic [7:0] m;
    logic [7:0] d;
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp = 8'h00;
    #1;
    chk("rst_busy",   16'(busy_two),  16'h0);
    chk("rst_done",   16'(done_two),  16'h0);
    chk("rst_pass",   16'(pass_two),  16'h0);
    chk("rst_cnt",    cnt_two,        16'h0);
    chk("rst_sig_fs", 16'(sig_full),  16'(FULL_SEED));
    tick(); rst = 1'b0;
    tick();

    // Session A: single pattern, latency, stall, extra data after last accept
    start = 1'b1; tick();
    chk("a_busy_run", 16'(busy_two), 16'h1);
    chk("a_cnt0",     cnt_two,       16'h0);
    start = 1'b0; resp = 8'h5A; resp_valid = 1'b1; tick();
    chk("one_sig",    16'(sig_one),  16'h5A);
    chk("one_cnt",    cnt_one,       16'h1);
    chk("one_busy_c", 16'(busy_one), 16'h1);
    chk("one_done_e0",16'(done_one), 16'h0);
    chk("two_sig1",   16'(sig_two),  16'h5A);
    resp_valid = 1'b0; tick();
    chk("one_done_e1",16'(done_one), 16'h0);
    chk("one_pass_e1",16'(pass_one), 16'h1);
    chk("one_busy_e1",16'(busy_one), 16'h0);
    tick();
    chk("one_done_e2",16'(done_one), 16'h1);
    chk("one_pass_e2",16'(pass_one), 16'h1);
    chk("stall_busy", 16'(busy_two), 16'h1);
    chk("stall_cnt",  cnt_two,       16'h1);
    tick();
    chk("stall_cnt3", cnt_two,       16'h1);
    chk("stall_sig",  16'(sig_two),  16'h5A);
    resp = 8'h3C; resp_valid = 1'b1; tick();
    chk("two_sig2",   16'(sig_two),  16'h88);
    chk("two_cnt2",   cnt_two,       16'h2);
    chk("two_done_e0",16'(done_two), 16'h0);
    resp = 8'hFF; tick();
    chk("extra_sig1", 16'(sig_two),  16'h88);
    chk("two_pass",   16'(pass_two), 16'h1);
    chk("bad_pass",   16'(pass_bad), 16'h0);
    tick();
    chk("extra_sig2", 16'(sig_two),  16'h88);
    chk("extra_cnt",  cnt_two,       16'h2);
    chk("two_done",   16'(done_two), 16'h1);
    chk("two_busy_d", 16'(busy_two), 16'h0);
    chk("bad_done",   16'(done_bad), 16'h1);
    chk("bad_sig",    16'(sig_bad),  16'h88);
    chk("bad_cnt",    cnt_bad,       16'h2);
    chk("bad_busy",   16'(busy_bad), 16'h0);
    chk("one_hold",   16'(sig_one),  16'h5A);
    resp_valid = 1'b0;

    // Session B: restart from DONE, start pulse mid-run ignored
    start = 1'b1; tick();
    chk("rs_done",    16'(done_two), 16'h0);
    chk("rs_pass",    16'(pass_two), 16'h0);
    chk("rs_cnt",     cnt_two,       16'h0);
    chk("rs_sig",     16'(sig_two),  16'h00);
    chk("rs_busy",    16'(busy_two), 16'h1);
    start = 1'b0; resp = 8'h5A; resp_valid = 1'b1; tick();
    chk("b_cnt1",     cnt_two,       16'h1);
    start = 1'b1; resp_valid = 1'b0; tick();
    chk("b_ign_cnt",  cnt_two,       16'h1);
    chk("b_ign_sig",  16'(sig_two),  16'h5A);
    chk("b_ign_busy", 16'(busy_two), 16'h1);
    start = 1'b0; resp = 8'h3C; resp_valid = 1'b1; tick();
    chk("b_sig",      16'(sig_two),  16'h88);
    resp_valid = 1'b0; tick(); tick();
    chk("b_done",     16'(done_two), 16'h1);
    chk("b_pass",     16'(pass_two), 16'h1);

    // Session C: asynchronous reset mid-session
    start = 1'b1; tick();
    start = 1'b0; resp = 8'h5A; resp_valid = 1'b1; tick();
    chk("c_cnt1",     cnt_two,       16'h1);
    resp_valid = 1'b0; rst = 1'b1; #1;
    chk("ar_busy",    16'(busy_two), 16'h0);
    chk("ar_done",    16'(done_one), 16'h0);
    chk("ar_pass",    16'(pass_two), 16'h0);
    chk("ar_sig",     16'(sig_two),  16'h00);
    chk("ar_cnt",     cnt_two,       16'h0);
    chk("ar_sig_fs",  16'(sig_full), 16'(FULL_SEED));
    chk("ar_cnt_f",   cnt_full,      16'h0);
    tick(); rst = 1'b0; tick();

    // Session D: full 255-pattern run; last word steers signature to FULL_GOLDEN
    start = 1'b1; tick();
    start = 1'b0;
    m = FULL_SEED;
    for (int i = 0; i < 255; i++) begin
      if (i % 50 == 25) begin
        resp_valid = 1'b0; tick();
      end
      d = (i == 254) ? (mstep(m, 8'h00) ^ FULL_GOLDEN) : pat(i);
      resp = d; resp_valid = 1'b1; tick();
      m = mstep(m, d);
      if (i == 253) begin
        chk("full_sig253", 16'(sig_full), 16'(m));
        chk("full_cnt253", cnt_full,      16'd254);
        chk("full_busy",   16'(busy_full), 16'h1);
      end
    end
    resp_valid = 1'b0;
    chk("full_sig",   16'(sig_full), 16'(FULL_GOLDEN));
    chk("full_cnt",   cnt_full,      16'd255);
    tick();
    chk("full_done1", 16'(done_full), 16'h0);
    tick();
    chk("full_done2", 16'(done_full), 16'h1);
    chk("full_pass",  16'(pass_full), 16'h1);
    chk("full_busy_d",16'(busy_full), 16'h0);
    chk("post_two_p", 16'(pass_two),  16'h1);
    chk("post_two_s", 16'(sig_two),   16'h88);
    chk("post_bad_p", 16'(pass_bad),  16'h0);
    chk("post_one_p", 16'(pass_one),  16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lbist_ora.md
Name: lbist_ora

Overview:
Output response analyzer for the LBIST loop. It sits on the output side of the circuit under test (the 8-bit adder's sum bus z) and compacts one response word per accepted cycle into a multiple-input signature register (MISR). After a programmed number of patterns it compares the signature with a golden value and reports pass/fail. It pairs with the LFSR pattern generator that drives the CUT inputs.

Parameters:
WIDTH, 8, response/signature width (matches the CUT output bus)
POLY, 8'hB8, MISR feedback tap mask (bit i set = misr[i] participates in feedback parity)
SEED, 8'h00, MISR value loaded on start
NUM_PATTERNS, 255, responses compacted per session (legal range 1 to 2^16-1)
GOLDEN, 8'h00, expected final signature

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin a session
resp_valid  in  1  resp holds a valid CUT response this cycle
resp  in  WIDTH  CUT output word (z)
busy  out  1  session in progress (RUN or CHECK)
done  out  1  session finished, result valid
pass  out  1  signature == GOLDEN; meaningful only while done=1
signature  out  WIDTH  current MISR contents
pat_count  out  16  responses accepted in the current session

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, misr=SEED, pat_count=0, busy=0, done=0, pass=0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE: start=1 loads misr=SEED and pat_count=0, then moves to RUN. resp_valid is ignored.
- RUN: on each cycle with resp_valid=1:
  - fb = XOR-reduce(misr & POLY)
  - misr_next = {misr[WIDTH-2:0], fb} ^ resp
  - pat_count increments
- RUN: resp_valid=0 stalls the session. misr and pat_count hold, and there is no timeout.
- RUN exit: the accept that makes pat_count reach NUM_PATTERNS moves the FSM to CHECK. Responses after that accept are not compacted.
- CHECK: one cycle. Registers pass = (misr == GOLDEN) and moves to DONE.
- Latency: done rises at the 2nd rising edge after the edge that accepted the last response.
- DONE: done=1, and pass, signature and pat_count hold. start=1 here restarts directly (reload SEED, clear count, go to RUN, clear done/pass in the same edge).
- start is ignored in RUN and CHECK; a session cannot be restarted mid-run.
- busy = (state == RUN || state == CHECK), registered with the state.
- rst asserted mid-session aborts immediately to reset values. The partial signature is discarded.
- pat_count width is 16 bits. NUM_PATTERNS never wraps it, because the session ends at the terminal count.
- Widths: all MISR arithmetic is GF(2) XOR, WIDTH bits. There is no carry and no extension.

Decomposition:
- Shared package lbist_pkg holds:
  - FSM state enum (IDLE/RUN/CHECK/DONE, 2-bit)
  - default POLY and SEED constants for the 8-bit LBIST width
  - pattern counter width constant (16), so the pattern-generator side uses the same count width
- One sub-module is natural: lbist_misr (WIDTH, POLY), with ports clk, rst, load, seed, en, din, q, implementing the shift/XOR update. lbist_ora holds the FSM, counter and compare.

Test Plan:
- Single pattern (NUM_PATTERNS=1, SEED=0): start, then resp=8'h5A with valid -> signature=8'h5A; done rises 2 edges later; pass=1 iff GOLDEN=8'h5A.
- Two patterns (NUM_PATTERNS=2, SEED=0, POLY=8'hB8): resp 8'h5A then 8'h3C -> signature=8'h88, pat_count=2. With GOLDEN=8'h88, pass=1; with GOLDEN=8'h89, pass=0.
- Stall handling: same two patterns with resp_valid low for 3 cycles between them -> identical signature 8'h88. busy stays 1 and pat_count holds at 1 during the gap.
- Start/extra-data robustness: start pulsed during RUN -> ignored, count unaffected. resp_valid held high after the last pattern -> signature unchanged after the CHECK transition.
- Reset mid-operation: assert rst after 1 of 2 responses -> busy=0, done=0, pass=0, signature=SEED, pat_count=0 asynchronously. A following session completes normally.
- Back-to-back sessions: start while in DONE -> done/pass clear on the next edge and a new session runs. Full NUM_PATTERNS=255 run against a reference-model signature -> pass=1.
